// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 op-codes,
// FSM state encodings and operand-signedness helpers. Decode uses the same
// op-code names so both sides agree on the funct3 mapping.
package muldiv_unit_pkg;

  // funct3 op-codes (RV32M/RV64M)
  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_e;

  // Divide ops all have funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f);
    return f[2];
  endfunction

  // operand1 is signed for everything except MULHU, DIVU and REMU.
  function automatic logic op1_signed(input logic [2:0] f);
    return (f != FUNC_MULHU) && !(f[2] && f[0]);
  endfunction

  // operand2 is signed only for MUL, MULH, DIV and REM.
  function automatic logic op2_signed(input logic [2:0] f);
    return (f == FUNC_MUL) || (f == FUNC_MULH) ||
           (f == FUNC_DIV) || (f == FUNC_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one step per cycle over XLEN cycles,
// with a shared 2*XLEN accumulator holding {product} or {remainder, quotient}.
// Divide-by-zero and signed-overflow divides skip CALC entirely.
//
// state  | meaning
// IDLE   | waiting for start; latches operands and magnitudes on accept
// CALC   | one shift-add / shift-subtract step per cycle, counter counts down
// FINISH | first cycle: sign-correct and register result; second: done pulse
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     state_q;
  logic [2:0]        func_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic              special_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] mul_acc_d;
  logic [2*XLEN-1:0] div_acc_d;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   result_d;

  // Decode the incoming request: signs, magnitudes and early-out cases.
  always_comb begin
    s1          = op1_signed(func) & operand1[XLEN-1];
    s2          = op2_signed(func) & operand2[XLEN-1];
    mag1        = s1 ? (~operand1 + 1'b1) : operand1;
    mag2        = s2 ? (~operand2 + 1'b1) : operand2;
    div_zero    = is_div_op(func) && (operand2 == '0);
    div_ovf     = is_div_op(func) && !func[0] &&
                  (operand1 == MOST_NEG) && (operand2 == '1);
    special_val = '0;
    if (div_zero) begin
      special_val = func[1] ? operand1 : '1;
    end else if (div_ovf) begin
      special_val = func[1] ? '0 : operand1;
    end
  end

  // One iteration step for each algorithm, computed from the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};
    div_trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    if (!div_trial[XLEN]) begin
      div_acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_acc_d = {acc_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection, registered on the first FINISH cycle.
  always_comb begin
    prod_fix = neg_q     ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q     ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fix  = rem_neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    result_d = '0;
    if (special_q) begin
      result_d = acc_q[XLEN-1:0];
    end else begin
      case (func_q)
        FUNC_MUL:                 result_d = prod_fix[XLEN-1:0];
        FUNC_MULH, FUNC_MULHSU,
        FUNC_MULHU:               result_d = prod_fix[2*XLEN-1:XLEN];
        FUNC_DIV, FUNC_DIVU:      result_d = quo_fix;
        default:                  result_d = rem_fix;
      endcase
    end
  end

  // Sequencer and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      func_q    <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            func_q    <= func;
            neg_q     <= s1 ^ s2;
            rem_neg_q <= s1;
            cnt_q     <= CNT_INIT;
            busy_q    <= 1'b1;
            if (div_zero || div_ovf) begin
              acc_q     <= {{XLEN{1'b0}}, special_val};
              b_q       <= '0;
              special_q <= 1'b1;
              state_q   <= FINISH;
            end else begin
              // Multiply: b_q is the multiplicand, low half the multiplier.
              // Divide: b_q is the divisor, low half the dividend.
              acc_q     <= {{XLEN{1'b0}}, is_div_op(func) ? mag1 : mag2};
              b_q       <= is_div_op(func) ? mag2 : mag1;
              special_q <= 1'b0;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= is_div_op(func_q) ? div_acc_d : mul_acc_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= FINISH;
          end
        end
        FINISH: begin
          if (!done_q) begin
            done_q   <= 1'b1;
            result_q <= result_d;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32 with hand-computed
// expected results and latencies (edges from the accepting start edge).
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      func;
  logic [XLEN-1:0] op1, op2;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .func     (func),
    .operand1 (op1),
    .operand2 (op2),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request and let it be sampled at the next rising edge (edge 0).
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    func  = f;
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, starting from edge n0; bounded.
  task automatic wait_done(input int n0, output int cnt);
    cnt = n0;
    while (done !== 1'b1 && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
    end
  endtask

  // Check the done cycle, then that done lasts one cycle and busy drops.
  task automatic finish_chk(input string tag, input int lat, input int exp_lat,
                            input logic [XLEN-1:0] exp_res);
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " res"}, result, exp_res);
    chk({tag, " busy@done"}, busy, 1);
    @(posedge clk);
    #1;
    chk({tag, " pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int exp_lat,
                        input logic [XLEN-1:0] exp_res);
    int lat;
    issue(f, a, b);
    wait_done(0, lat);
    finish_chk(tag, lat, exp_lat, exp_res);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func  = '0;
    op1   = '0;
    op2   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    rst = 1'b0;

    // MUL 10*20 with a stray start at edge 5 that must be ignored
    issue(FUNC_MUL, 32'd10, 32'd20);
    @(posedge clk);
    #1;
    chk("t1 busy e1", busy, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    func  = FUNC_DIVU;
    op1   = 32'd7;
    op2   = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("t1 done e5", done, 0);
    wait_done(5, n);
    finish_chk("t1 mul", n, 33, 32'd200);

    // Multiply variants
    run_op("mulh",   FUNC_MULH,   32'hFFFF_FFF6, 32'd1, 33, 32'hFFFF_FFFF);
    run_op("mulhu",  FUNC_MULHU,  32'hFFFF_FFF6, 32'd1, 33, 32'h0000_0000);
    run_op("mulhsu", FUNC_MULHSU, 32'hFFFF_FFF6, 32'd1, 33, 32'hFFFF_FFFF);
    run_op("mul neg", FUNC_MUL,   32'hFFFF_FFF6, 32'd1, 33, 32'hFFFF_FFF6);
    run_op("mulh mn", FUNC_MULH,  32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);

    // Divide variants
    run_op("div",  FUNC_DIV,  32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFA);
    run_op("rem",  FUNC_REM,  32'hFFFF_FFEC, 32'd3, 33, 32'hFFFF_FFFE);
    run_op("divu", FUNC_DIVU, 32'd20, 32'd3, 33, 32'd6);
    run_op("remu", FUNC_REMU, 32'd20, 32'd3, 33, 32'd2);

    // Early-out cases
    run_op("divu /0", FUNC_DIVU, 32'd7, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("remu /0", FUNC_REMU, 32'd7, 32'd0, 1, 32'd7);
    run_op("div /0",  FUNC_DIV,  32'd5, 32'd0, 1, 32'hFFFF_FFFF);
    run_op("div ovf", FUNC_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem ovf", FUNC_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000);
    run_op("divu noovf", FUNC_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000);

    // Back-to-back: second start lands in the cycle right after done
    run_op("b2b mulhu", FUNC_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("b2b remu",  FUNC_REMU,  32'hFFFF_FFFF, 32'h0000_0010, 33, 32'h0000_000F);

    // Reset mid-operation discards the DIV; then a fresh MUL 3*4
    issue(FUNC_DIV, 32'hFFFF_FFEC, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    chk("mid rst result", result, 0);
    @(posedge clk);
    #1;
    chk("post rst done", done, 0);
    run_op("mul after rst", FUNC_MUL, 32'd3, 32'd4, 33, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit implementing the RV32M/RV64M operation set alongside the combinational ALU. It is parametrised in XLEN and performs radix-2 shift-add multiply and restoring divide over XLEN cycles. Special divide cases finish early. A start/busy/done handshake lets the decode/execute stage stall while the unit works.

Parameters:
XLEN, 32, operand and result width in bits (any value >= 4; 32 and 64 supported).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only in IDLE
func  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand1  input  XLEN  rs1 value (multiplicand / dividend)
operand2  input  XLEN  rs2 value (multiplier / divisor)
busy  output  1  high while an operation is in progress (CALC or FINISH)
done  output  1  one-cycle pulse; result valid in the same cycle
result  output  XLEN  final result; held until the next accepted start or reset

Behaviour:
- Reset (rst high at a clock edge): state IDLE, busy=0, done=0, result=0, all internal registers cleared. Reset has priority over everything, including mid-operation; any in-flight operation is discarded with no done pulse.
- States:
  - IDLE: on start=1, latch func and operands, compute sign/magnitudes, set counter=XLEN. Normal case goes to CALC. Special divide case goes to FINISH.
  - CALC: one radix-2 step per cycle, counter decrements. When counter reaches 0, go to FINISH.
  - FINISH: apply sign correction and select the result; done=1 for exactly this cycle; then go to IDLE.
- Latency, counting the start edge as edge 0:
  - Normal: done high in the cycle after edge XLEN+1 (33 cycles for XLEN=32).
  - Early-out: done high in the cycle after edge 1.
  - busy is high from edge 1 until done falls.
- start while busy is ignored; operands are not re-latched. start in the FINISH cycle is also ignored. back-to-back start is accepted in the cycle after done.
- Multiply:
  - Operands are converted to magnitudes. MUL/MULH treat both as signed; MULHSU treats operand1 signed and operand2 unsigned; MULHU treats both unsigned.
  - A 2*XLEN-bit product is accumulated and negated in FINISH if the signs differ.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2*XLEN-1:XLEN].
- Divide:
  - Restoring algorithm on magnitudes (signed for DIV/REM). Quotient sign = sign1 XOR sign2; remainder sign = sign of dividend.
  - Divisor 0 (early-out): DIV/DIVU return all ones; REM/REMU return operand1.
  - Signed overflow, DIV/REM only, with operand1 = most negative and operand2 = all ones (early-out): DIV returns operand1; REM returns 0.
- All arithmetic is modulo 2^XLEN on output. No exceptions or flags.

Decomposition:
- Shared include muldiv_defs.vh, also used by decode, holds:
  - the funct3 op-code defines (MUL..REMU);
  - state encodings IDLE=2'd0, CALC=2'd1, FINISH=2'd2.
- Keep the unit in a single module. The datapath (abs/negate, shared 2*XLEN shift register for product/remainder) and the FSM are small enough that a sub-module adds nothing.

Test Plan:
- MUL 10*20 (XLEN=32), start at edge 0 -> busy=1 at edge 1, done=1 after edge 33, result=200. A start pulse at edge 5 with other operands is ignored; the result is still 200.
- operand1=0xFFFFFFF6, operand2=1 -> MULH=0xFFFFFFFF, MULHU=0x00000000, MULHSU=0xFFFFFFFF, MUL=0xFFFFFFF6.
- DIV 0xFFFFFFEC (-20) / 3 -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); DIVU 20/3 -> 6; REMU -> 2.
- DIVU 7/0 -> done after edge 1 with result 0xFFFFFFFF; REMU 7/0 -> 7; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 early-out; REM of the same operands -> 0.
- DIV started, rst=1 at edge 10 -> busy=0, done=0, result=0 after edge 10 with no later done pulse. A new MUL 3*4 started at edge 12 -> done after edge 45 with result 12.
- Back-to-back ops: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE, with a new start in the cycle after done. Then REMU 0xFFFFFFFF/0x10 -> 0xF. Both done pulses are exactly one cycle wide.
